// File: rtl/regfile16_wide.sv
// 16-entry register file: one synchronous write port, two combinational read ports,
// optional hardwired-zero entry 15 and optional same-cycle write-to-read bypass.
module regfile16_wide #(
  parameter int unsigned WIDTH    = 64,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [3:0]       rd_addr_a,
  input  logic [3:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  localparam int unsigned NUM_REGS = 16;
  localparam logic [3:0]  ZERO_IDX = 4'hF;

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel_c;
  logic                bypass_en_c;

  // One-hot write decoder; the hardwired-zero entry never gets an enable.
  always_comb begin
    wr_sel_c = '0;
    if (wr_en) wr_sel_c = NUM_REGS'(1) << wr_addr;
    if (ZERO_REG) wr_sel_c[ZERO_IDX] = 1'b0;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_next
    assign regs_d[g] = wr_sel_c[g] ? wr_data : regs_q[g];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '{default: '0};
    else          regs_q <= regs_d;
  end

  always_comb begin
    bypass_en_c = BYPASS && wr_en && reset_n && !(ZERO_REG && (wr_addr == ZERO_IDX));
  end

  // Read muxes: stored value, overridden by bypass, forced to zero last.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (bypass_en_c && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if (!reset_n || (ZERO_REG && (rd_addr_a == ZERO_IDX))) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if (bypass_en_c && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
    if (!reset_n || (ZERO_REG && (rd_addr_b == ZERO_IDX))) rd_data_b = '0;
  end

endmodule

// File: tb/tb_regfile16_wide.sv
// Bench for regfile16_wide: a bypassing and a non-bypassing instance share stimulus and
// are checked every cycle against an array model, plus hand-computed literal checks.
module tb_regfile16_wide;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [3:0]   rd_addr_a;
  logic [3:0]   rd_addr_b;
  logic [W-1:0] rd_a_byp, rd_b_byp, rd_a_nb, rd_b_nb;

  int n_checks = 0;
  int n_bad    = 0;
  bit cmp_on   = 1'b0;

  logic [W-1:0] mem [16];

  regfile16_wide #(.WIDTH(W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a_byp), .rd_data_b(rd_b_byp)
  );

  regfile16_wide #(.WIDTH(W), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a_nb), .rd_data_b(rd_b_nb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What a read port must show right now, from the architectural rules.
  function automatic logic [W-1:0] model_read(input logic [3:0] addr, input bit byp);
    if (reset_n !== 1'b1) return '0;
    if (addr == 4'd15) return '0;
    if (byp && (wr_en === 1'b1) && (addr == wr_addr) && (wr_addr != 4'd15)) return wr_data;
    return mem[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  // Advance one rising edge, commit any qualified write to the model, settle.
  task automatic tick();
    @(posedge clk);
    if ((reset_n === 1'b1) && (wr_en === 1'b1) && (wr_addr != 4'd15)) mem[wr_addr] = wr_data;
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_byp_a", rd_a_byp, model_read(rd_addr_a, 1'b1));
      check("cyc_byp_b", rd_b_byp, model_read(rd_addr_b, 1'b1));
      check("cyc_nb_a",  rd_a_nb,  model_read(rd_addr_a, 1'b0));
      check("cyc_nb_b",  rd_b_nb,  model_read(rd_addr_b, 1'b0));
    end
  end

  initial begin
    logic [W-1:0] step;
    step      = 64'h1111_1111_1111_1111;
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    model_clear();
    cmp_on = 1'b1;
    tick(); tick();
    check("reset_rd_a", rd_a_byp, 64'h0);
    reset_n = 1'b1;

    // Reset clears immediately, without a clock edge.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 64'hDEAD_BEEF_0000_0001; rd_addr_a = 4'd3;
    tick();
    wr_en = 1'b0;
    #1 check("wr3_stored", rd_a_nb, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk); #2;
    reset_n = 1'b0; model_clear();
    #1 check("async_clr_byp", rd_a_byp, 64'h0);
    check("async_clr_nb", rd_a_nb, 64'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      tick();
    end
    rd_addr_a = 4'd3;
    #1 check("post_reset_e3", rd_a_nb, 64'h0);

    // Fill entries 0..14, then sweep both ports in opposite directions.
    wr_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wr_addr = 4'(i); wr_data = step * 64'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      tick();
    end
    rd_addr_a = 4'd7; rd_addr_b = 4'd15;
    #1 check("fill_e7", rd_a_byp, 64'h7777_7777_7777_7777);
    check("fill_e15_zero", rd_b_byp, 64'h0);
    rd_addr_a = 4'd14; rd_addr_b = 4'd1;
    #1 check("fill_e14", rd_a_nb, 64'hEEEE_EEEE_EEEE_EEEE);
    check("fill_e1", rd_b_nb, 64'h1111_1111_1111_1111);

    // Writes to entry 15 vanish, even through the bypass.
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = '1; rd_addr_a = 4'd15; rd_addr_b = 4'd15;
    #2 check("zero_pre_edge", rd_a_byp, 64'h0);
    tick();
    wr_en = 1'b0;
    #1 check("zero_post_edge", rd_a_byp, 64'h0);
    check("zero_post_edge_nb", rd_b_nb, 64'h0);

    // Bypass versus stored-value reads on a same-cycle write.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 64'hA;
    tick();
    wr_data = 64'hB; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    #2 check("byp_a_pre", rd_a_byp, 64'hB);
    check("byp_b_pre", rd_b_byp, 64'hB);
    check("nb_a_pre", rd_a_nb, 64'hA);
    check("nb_b_pre", rd_b_nb, 64'hA);
    tick();
    wr_en = 1'b0;
    #1 check("nb_a_post", rd_a_nb, 64'hB);
    check("nb_b_post", rd_b_nb, 64'hB);

    // wr_en low: nothing changes, even with unknown address/data.
    wr_addr = 4'd7; wr_data = 64'h1234; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    tick(); tick(); tick();
    check("wr_dis_e7", rd_a_byp, 64'h7777_7777_7777_7777);
    wr_addr = 'x; wr_data = 'x;
    tick();
    check("wr_dis_x_e7", rd_b_nb, 64'h7777_7777_7777_7777);
    wr_addr = '0; wr_data = '0;

    // Reset asserted on the same timestep as a write edge: reset wins.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 64'h55; rd_addr_a = 4'd2; rd_addr_b = 4'd2;
    @(posedge clk);
    reset_n = 1'b0; model_clear();
    #1 wr_en = 1'b0;
    tick();
    reset_n = 1'b1;
    #1 check("collide_e2_byp", rd_a_byp, 64'h0);
    check("collide_e2_nb", rd_b_nb, 64'h0);
    tick();
    check("collide_e2_later", rd_a_nb, 64'h0);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
